// File: rtl/fft_addr_gen.sv
// Radix-2 DIT butterfly address sequencer for an in-place FFT.
// Walks every butterfly of every stage of a runtime-selected N-point FFT and
// presents the two operand addresses plus the twiddle (k, n) pair for each one.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start, n_points       frame request and FFT size (sampled only in IDLE)
//   out_ready             downstream accepts the presented butterfly
//   busy                  frame in progress (RUN or GAP)
//   out_valid             butterfly fields below are valid
//   addr_a, addr_b        top / bottom operand addresses
//   tw_k, tw_n            twiddle ROM index and size
//   stage, stage_last     current stage, last butterfly of the stage
//   done, err             one-cycle pulses: frame complete / illegal n_points
module fft_addr_gen #(
    parameter int unsigned MAX_N       = 32,
    parameter int unsigned ADDR_WIDTH  = $clog2(MAX_N),
    parameter int unsigned STAGE_GAP   = 4,
    localparam int unsigned STAGE_WIDTH = $clog2(ADDR_WIDTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH:0]    n_points,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   out_valid,
    output logic [ADDR_WIDTH-1:0]  addr_a,
    output logic [ADDR_WIDTH-1:0]  addr_b,
    output logic [ADDR_WIDTH-1:0]  tw_k,
    output logic [ADDR_WIDTH:0]    tw_n,
    output logic [STAGE_WIDTH-1:0] stage,
    output logic                   stage_last,
    output logic                   done,
    output logic                   err
);

    localparam int unsigned NW         = ADDR_WIDTH + 1;
    localparam int unsigned GAP_WIDTH  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam int unsigned GAP_LAST_I = (STAGE_GAP > 0) ? STAGE_GAP - 1 : 0;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

    state_t                 state;
    logic [ADDR_WIDTH-1:0]  b_idx;
    logic [ADDR_WIDTH-1:0]  b_last;
    logic [STAGE_WIDTH-1:0] s_last;
    logic [GAP_WIDTH-1:0]   gap_cnt;

    logic                   n_legal;
    logic [STAGE_WIDTH-1:0] n_log;
    logic [ADDR_WIDTH-1:0]  start_b_last;

    logic [STAGE_WIDTH-1:0] sel_s;
    logic [ADDR_WIDTH-1:0]  sel_b;
    logic [ADDR_WIDTH-1:0]  sel_b_last;
    logic [ADDR_WIDTH-1:0]  half_mask;
    logic [ADDR_WIDTH-1:0]  pres_a;
    logic [ADDR_WIDTH-1:0]  pres_b;
    logic [ADDR_WIDTH-1:0]  pres_k;
    logic [ADDR_WIDTH:0]    pres_n;
    logic                   pres_last;

    // Size decode: legality and log2 of a power-of-two n_points
    always_comb begin
        n_log = '0;
        for (int i = 0; i <= int'(ADDR_WIDTH); i++) begin
            if (n_points[i]) n_log = STAGE_WIDTH'(i);
        end
        n_legal = (n_points >= NW'(2)) && (n_points <= NW'(MAX_N)) &&
                  ((n_points & (n_points - NW'(1))) == '0);
        start_b_last = ADDR_WIDTH'((n_points >> 1) - NW'(1));
    end

    // Butterfly that would be presented next, and its address/twiddle fields
    always_comb begin
        sel_s      = stage;
        sel_b      = b_idx + ADDR_WIDTH'(1);
        sel_b_last = b_last;
        case (state)
            S_IDLE: begin
                sel_s      = '0;
                sel_b      = '0;
                sel_b_last = start_b_last;
            end
            S_RUN: begin
                if (stage_last) begin
                    sel_s = stage + STAGE_WIDTH'(1);
                    sel_b = '0;
                end
            end
            S_GAP: begin
                sel_s = stage + STAGE_WIDTH'(1);
                sel_b = '0;
            end
            default: ;
        endcase
        // Low s bits of b are j; the remaining bits are the group index,
        // which lands one place higher because groups are 2*half apart.
        half_mask = (ADDR_WIDTH'(1) << sel_s) - ADDR_WIDTH'(1);
        pres_a    = ((sel_b & ~half_mask) << 1) | (sel_b & half_mask);
        pres_b    = pres_a | (half_mask + ADDR_WIDTH'(1));
        pres_k    = sel_b & half_mask;
        pres_n    = NW'(2) << sel_s;
        pres_last = (sel_b == sel_b_last);
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            b_idx      <= '0;
            b_last     <= '0;
            s_last     <= '0;
            gap_cnt    <= '0;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            addr_a     <= '0;
            addr_b     <= '0;
            tw_k       <= '0;
            tw_n       <= '0;
            stage      <= '0;
            stage_last <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (n_legal) begin
                            b_last     <= start_b_last;
                            s_last     <= n_log - STAGE_WIDTH'(1);
                            stage      <= sel_s;
                            b_idx      <= sel_b;
                            addr_a     <= pres_a;
                            addr_b     <= pres_b;
                            tw_k       <= pres_k;
                            tw_n       <= pres_n;
                            stage_last <= pres_last;
                            out_valid  <= 1'b1;
                            busy       <= 1'b1;
                            state      <= S_RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (out_ready) begin
                        if (stage_last && (stage == s_last)) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_DONE;
                        end else if (stage_last && (STAGE_GAP != 0)) begin
                            out_valid <= 1'b0;
                            gap_cnt   <= '0;
                            state     <= S_GAP;
                        end else begin
                            stage      <= sel_s;
                            b_idx      <= sel_b;
                            addr_a     <= pres_a;
                            addr_b     <= pres_b;
                            tw_k       <= pres_k;
                            tw_n       <= pres_n;
                            stage_last <= pres_last;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_WIDTH'(GAP_LAST_I)) begin
                        stage      <= sel_s;
                        b_idx      <= sel_b;
                        addr_a     <= pres_a;
                        addr_b     <= pres_b;
                        tw_k       <= pres_k;
                        tw_n       <= pres_n;
                        stage_last <= pres_last;
                        out_valid  <= 1'b1;
                        state      <= S_RUN;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_WIDTH'(1);
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
